// File: rtl/tdoa_angle_tracker_pkg.sv
// Shared types and helpers for the TDOA angle tracker.
// Holds the FSM state enum, the LUT centre address and the delay clamp.
package utils;

   localparam int ADDR_W_DEF  = 8;
   localparam int ADDR_CENTER = 1 << (ADDR_W_DEF - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_LOOKUP,
      ST_READ,
      ST_SEND,
      ST_GUARD,
      ST_HOLDOFF
   } tdoa_state_t;

   // Symmetric saturation of a signed delay to +/-lim.
   function automatic logic signed [31:0] clamp_delay(
      input logic signed [31:0] v,
      input int                 lim
   );
      if (v > lim)
         return lim;
      else if (v < -lim)
         return -lim;
      return v;
   endfunction

endpackage

// File: rtl/tdoa_angle_tracker_if.sv
// LUT and UART side-channel bundle of the TDOA angle tracker.
// master = tracker, slave = ROM/UART side.
interface tdoa_angle_tracker_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] lut_addr;
   logic [7:0]        lut_data;
   logic              tx_busy;
   logic [7:0]        tx_data;
   logic              tx_valid;

   modport master (
      output lut_addr,
      output tx_data,
      output tx_valid,
      input  lut_data,
      input  tx_busy
   );

   modport slave (
      input  lut_addr,
      input  tx_data,
      input  tx_valid,
      output lut_data,
      output tx_busy
   );
endinterface

// File: rtl/tdoa_angle_tracker_onset_timestamper.sv
// Per-channel onset edge detect, window counter and first-arrival stamps.
// cap_next/ts_next show the state including this cycle's edges.
module onset_timestamper #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       onset,
   input  logic                    arm,
   input  logic                    run,
   output logic                    start,
   output logic [CNT_W-1:0]        cnt,
   output logic [NUM_CH-1:0]       cap_next,
   output logic [NUM_CH*CNT_W-1:0] ts_next
);

   logic [NUM_CH-1:0]       onset_q;
   logic [NUM_CH-1:0]       edges;
   logic [NUM_CH-1:0]       cap;
   logic [NUM_CH*CNT_W-1:0] ts;

   assign edges = onset & ~onset_q;
   assign start = arm & (|edges);

   // First edge per channel latches the running counter; later ones are ignored.
   always_comb begin
      cap_next = cap;
      ts_next  = ts;
      if (run) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (edges[i] && !cap[i]) begin
               cap_next[i]                = 1'b1;
               ts_next[i*CNT_W +: CNT_W] = cnt;
            end
         end
      end
   end

   // Onset history tracks in every state so a held level is never an edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         onset_q <= '0;
      else
         onset_q <= onset;
   end

   // Window start stamps edge channels at 0; capture advances the counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cap <= '0;
         ts  <= '0;
         cnt <= '0;
      end else if (start) begin
         cap <= edges;
         ts  <= '0;
         cnt <= CNT_W'(1);
      end else if (run) begin
         cap <= cap_next;
         ts  <= ts_next;
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/tdoa_angle_tracker.sv
// TDOA angle tracker: pair delay -> LUT address -> angle byte to UART.
// Optional RAW_DELAY_EN also sends the clamped shifted delay byte.
module tdoa_angle_tracker
   import utils::*;
#(
   parameter int NUM_CH      = 2,
   parameter int CNT_W       = 16,
   parameter int MAX_WINDOW  = 4096,
   parameter int PAIR_A      = 0,
   parameter int PAIR_B      = 1,
   parameter int DELAY_SHIFT = 4,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int HOLDOFF     = 100_000_000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_CH-1:0]    onset,
   tdoa_angle_tracker_if.master bus,
   output logic                 meas_done,
   output logic                 timeout
);

   localparam int CTR    = (ADDR_W == ADDR_W_DEF) ? ADDR_CENTER
                                                  : (1 << (ADDR_W - 1));
   localparam int LIM    = CTR - 1;
   localparam int HOLD_W = 27;

   tdoa_state_t state;
   tdoa_state_t state_nx;

   logic                    start;
   logic [CNT_W-1:0]        cnt;
   logic [NUM_CH-1:0]       cap_next;
   logic [NUM_CH*CNT_W-1:0] ts_next;
   logic                    done;
   logic                    pair_ok;
   logic [CNT_W-1:0]        t_a;
   logic [CNT_W-1:0]        t_b;
   logic signed [CNT_W:0]   d;
   logic signed [31:0]      d_ext;
   logic signed [31:0]      s;
   logic [ADDR_W-1:0]       addr_c;
   logic [HOLD_W-1:0]       hold_cnt;
   logic                    unused;

`ifdef RAW_DELAY_EN
   logic [7:0] s_q;
   logic       byte_idx;
`endif

   onset_timestamper #(
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W)
   ) u_ts (
      .clock    (clock),
      .reset    (reset),
      .onset    (onset),
      .arm      (state == ST_IDLE),
      .run      (state == ST_CAPTURE),
      .start    (start),
      .cnt      (cnt),
      .cap_next (cap_next),
      .ts_next  (ts_next)
   );

   assign t_a     = ts_next[PAIR_A*CNT_W +: CNT_W];
   assign t_b     = ts_next[PAIR_B*CNT_W +: CNT_W];
   assign d       = $signed({1'b0, t_b}) - $signed({1'b0, t_a});
   assign d_ext   = 32'(d);
   assign s       = clamp_delay(d_ext >>> DELAY_SHIFT, LIM);
   assign addr_c  = ADDR_W'(s + 32'(CTR));
   assign done    = (&cap_next) || (cnt == CNT_W'(MAX_WINDOW));
   assign pair_ok = cap_next[PAIR_A] && cap_next[PAIR_B];
   assign unused  = ^{ts_next, s};

   assign meas_done    = (state == ST_CAPTURE) && done;
   assign bus.tx_valid = (state == ST_SEND) && !bus.tx_busy;

   // State register; reset aborts any capture or send in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   // Next-state logic of the capture/lookup/send/holdoff sequence.
   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:
            if (start)
               state_nx = ST_CAPTURE;
         ST_CAPTURE:
            if (done)
               state_nx = pair_ok ? ST_LOOKUP : ST_HOLDOFF;
         ST_LOOKUP:
            state_nx = ST_READ;
         ST_READ:
            state_nx = ST_SEND;
         ST_SEND:
            if (!bus.tx_busy)
               state_nx = ST_GUARD;
         ST_GUARD:
`ifdef RAW_DELAY_EN
            state_nx = byte_idx ? ST_HOLDOFF : ST_SEND;
`else
            state_nx = ST_HOLDOFF;
`endif
         ST_HOLDOFF:
            if (hold_cnt == HOLD_W'(HOLDOFF - 1))
               state_nx = ST_IDLE;
         default:
            state_nx = ST_IDLE;
      endcase
   end

   // Address, output byte, timeout flag and holdoff counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.lut_addr <= ADDR_W'(CTR);
         bus.tx_data  <= '0;
         timeout      <= 1'b0;
         hold_cnt     <= '0;
`ifdef RAW_DELAY_EN
         s_q          <= '0;
         byte_idx     <= 1'b0;
`endif
      end else begin
         if (state == ST_IDLE && start)
            timeout <= 1'b0;
         if (state == ST_CAPTURE && done) begin
            if (!pair_ok) begin
               timeout <= 1'b1;
            end else begin
               bus.lut_addr <= addr_c;
`ifdef RAW_DELAY_EN
               s_q          <= s[7:0];
`endif
            end
         end
         if (state == ST_READ) begin
            bus.tx_data <= bus.lut_data;
`ifdef RAW_DELAY_EN
            byte_idx    <= 1'b0;
`endif
         end
`ifdef RAW_DELAY_EN
         if (state == ST_GUARD && !byte_idx) begin
            bus.tx_data <= s_q;
            byte_idx    <= 1'b1;
         end
`endif
         if (state == ST_HOLDOFF)
            hold_cnt <= hold_cnt + HOLD_W'(1);
         else
            hold_cnt <= '0;
      end
   end

endmodule
